// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the single-write-port register file: shares the port between
// the WB stage and a buffered multi-cycle result, and keeps a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pipe_we_i,
  input  logic [ADDR_W-1:0]       pipe_rd_i,
  input  logic [DATA_W-1:0]       pipe_data_i,
  input  logic                    mc_issue_i,
  input  logic [ADDR_W-1:0]       mc_issue_rd_i,
  input  logic                    mc_valid_i,
  input  logic [ADDR_W-1:0]       mc_rd_i,
  input  logic [DATA_W-1:0]       mc_data_i,
  output logic                    mc_ready_o,
  output logic                    rf_we_o,
  output logic [ADDR_W-1:0]       rf_rd_o,
  output logic [DATA_W-1:0]       rf_data_o,
  input  logic [ADDR_W-1:0]       dec_rs1_i,
  input  logic [ADDR_W-1:0]       dec_rs2_i,
  input  logic                    dec_we_i,
  input  logic [ADDR_W-1:0]       dec_rd_i,
  output logic                    stall_o,
  output logic [(1<<ADDR_W)-1:0]  busy_o
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [NREG-1:0]  NO_X0   = {{(NREG-1){1'b1}}, 1'b0};

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic [CNT_W-1:0]  starve_cnt;
  logic [NREG-1:0]   busy;

  logic            pipe_active;
  logic            drain;
  logic            accept;
  logic            starve;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign pipe_active = pipe_we_i & (pipe_rd_i != '0);
  assign drain       = buf_valid & ~pipe_active;
  assign accept      = mc_valid_i & mc_ready_o;
  assign starve      = (starve_cnt == CNT_MAX);

  assign mc_ready_o = rst_i & ~buf_valid;
  assign busy_o     = busy;

  // A drained entry addressed to x0 is discarded rather than written.
  always_comb begin
    rf_we_o   = 1'b0;
    rf_rd_o   = '0;
    rf_data_o = '0;
    if (rst_i) begin
      if (pipe_active) begin
        rf_we_o   = 1'b1;
        rf_rd_o   = pipe_rd_i;
        rf_data_o = pipe_data_i;
      end else if (drain) begin
        rf_we_o   = (buf_rd != '0);
        rf_rd_o   = buf_rd;
        rf_data_o = buf_data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mc_issue_i) set_mask[mc_issue_rd_i] = 1'b1;
    if (drain)      clr_mask[buf_rd]        = 1'b1;
  end

  assign stall_o = rst_i & (busy[dec_rs1_i] | busy[dec_rs2_i] |
                            (dec_we_i & busy[dec_rd_i]) | starve);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_valid  <= 1'b0;
      buf_rd     <= '0;
      buf_data   <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      if (drain) begin
        buf_valid <= 1'b0;
      end else if (accept) begin
        buf_valid <= 1'b1;
        buf_rd    <= mc_rd_i;
        buf_data  <= mc_data_i;
      end

      if (!buf_valid || drain)
        starve_cnt <= '0;
      else if (!starve)
        starve_cnt <= starve_cnt + 1'b1;

      // Set is applied after clear so a same-cycle reissue keeps the register pending.
      busy <= ((busy & ~clr_mask) | set_mask) & NO_X0;
    end
  end

endmodule
